// File: rtl/fifo_stream_reader.sv
// Drains a single-clock FIFO with 1-cycle read latency into a valid/ready stream.
// A 2-entry skid queue absorbs the latency; every BURST_LEN-th word is flagged with out_last.
module fifo_stream_reader #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [CW-1:0]     ccnt_q, ccnt_d, bcnt_q, bcnt_d;
  logic              busy_q;

  logic              pop;
  logic              cap;
  logic              cap_to_head;
  logic [2:0]        occ;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data0_q;
  assign out_last  = last0_q & out_valid;
  assign busy      = busy_q;

  assign pop = out_valid & out_ready;
  assign cap = inflight_q;

  // Occupancy after this cycle's pop, counting the word already requested from the FIFO.
  assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = !rst & (state_q == RUN) & en & !buf_empty & (occ < 3'd2);

  // A capture lands in the head slot when the queue is empty after this cycle's pop.
  assign cap_to_head = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);

  always_comb begin
    cnt_d   = cnt_q + {1'b0, cap} - {1'b0, pop};
    data0_d = pop ? data1_q : data0_q;
    last0_d = pop ? last1_q : last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    ccnt_d  = ccnt_q;
    bcnt_d  = bcnt_q;

    if (cap) begin
      if (cap_to_head) begin
        data0_d = buf_out;
        last0_d = (ccnt_q == LAST_IDX);
      end else begin
        data1_d = buf_out;
        last1_d = (ccnt_q == LAST_IDX);
      end
      ccnt_d = (ccnt_q == LAST_IDX) ? '0 : ccnt_q + CW'(1);
    end

    if (pop) begin
      bcnt_d = (bcnt_q == LAST_IDX) ? '0 : bcnt_q + CW'(1);
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = ((cnt_q != 2'd0) || inflight_q) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (en)                                    state_d = RUN;
        else if ((cnt_q == 2'd0) && !inflight_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
      ccnt_q     <= '0;
      bcnt_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd_en;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
      ccnt_q     <= ccnt_d;
      bcnt_q     <= bcnt_d;
      busy_q     <= (state_d != IDLE);
    end
  end

endmodule
